// File: rtl/conv2d_engine.sv
// Zero-padded same-size 2D convolution engine over a single-outstanding read port and a posted write port.
// Build option: define CONV_RELU_EN to clamp negative results to zero before they are written.
module conv2d_engine #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int WT_DIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              conv_start_i,
  input  logic              conv_rst_i,
  input  logic [AWIDTH-1:0] conv_ifm_offset_i,
  input  logic [AWIDTH-1:0] conv_ofm_offset_i,
  input  logic [AWIDTH-1:0] conv_wt_offset_i,
  input  logic [31:0]       conv_fm_dim_i,
  output logic              conv_idle_o,
  output logic              conv_done_o,
  output logic              rd_req_valid_o,
  input  logic              rd_req_ready_i,
  output logic [AWIDTH-1:0] rd_req_addr_o,
  input  logic              rd_resp_valid_i,
  input  logic [DWIDTH-1:0] rd_resp_data_i,
  output logic              wr_req_valid_o,
  input  logic              wr_req_ready_i,
  output logic [AWIDTH-1:0] wr_req_addr_o,
  output logic [DWIDTH-1:0] wr_req_data_o
);

  localparam int NTAP = WT_DIM * WT_DIM;
  localparam int PAD  = WT_DIM / 2;
  localparam int KW   = $clog2(NTAP + 1);
  localparam int TW   = $clog2(WT_DIM + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_WT = 3'd1;
  localparam logic [2:0] S_TAP     = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [AWIDTH-1:0] ifm_q, ifm_d, ofm_q, ofm_d, wt_q, wt_d;
  logic [15:0]       dim_q, dim_d, r_q, r_d, c_q, c_d;
  logic [TW-1:0]     ky_q, ky_d, kx_q, kx_d;
  logic [KW-1:0]     k_q, k_d;
  logic [DWIDTH-1:0] acc_q, acc_d;
  logic              wait_q, wait_d, stale_q, stale_d;
  logic [DWIDTH-1:0] w_q [NTAP];

  logic [17:0] iy, ix;
  logic        inb, rd_fire, resp, last_tap, w_we;
  logic        unused_dim_hi;

  assign unused_dim_hi = ^conv_fm_dim_i[31:16];

  assign iy  = 18'(r_q) + 18'(ky_q) - 18'(PAD);
  assign ix  = 18'(c_q) + 18'(kx_q) - 18'(PAD);
  assign inb = !iy[17] && !ix[17] && (iy[16:0] < 17'(dim_q)) && (ix[16:0] < 17'(dim_q));

  // A stale response left over from an abort must drain before any new request goes out.
  assign rd_req_valid_o = !wait_q && !stale_q &&
                          ((state_q == S_LOAD_WT) || ((state_q == S_TAP) && inb));
  assign rd_req_addr_o  = (state_q == S_LOAD_WT) ? wt_q + (AWIDTH'(k_q) << 2) :
                          ifm_q + ((AWIDTH'(iy[15:0]) * AWIDTH'(dim_q) + AWIDTH'(ix[15:0])) << 2);
  assign rd_fire  = rd_req_valid_o && rd_req_ready_i;
  assign resp     = wait_q && rd_resp_valid_i;
  assign last_tap = (k_q == KW'(NTAP - 1));
  assign w_we     = (state_q == S_LOAD_WT) && resp;

  assign conv_idle_o    = (state_q == S_IDLE);
  assign conv_done_o    = (state_q == S_DONE);
  assign wr_req_valid_o = (state_q == S_WRITE);
  assign wr_req_addr_o  = ofm_q + ((AWIDTH'(r_q) * AWIDTH'(dim_q) + AWIDTH'(c_q)) << 2);
`ifdef CONV_RELU_EN
  assign wr_req_data_o  = acc_q[DWIDTH-1] ? '0 : acc_q;
`else
  assign wr_req_data_o  = acc_q;
`endif

  always_comb begin
    state_d = state_q;
    ifm_d   = ifm_q;
    ofm_d   = ofm_q;
    wt_d    = wt_q;
    dim_d   = dim_q;
    r_d     = r_q;
    c_d     = c_q;
    ky_d    = ky_q;
    kx_d    = kx_q;
    k_d     = k_q;
    acc_d   = acc_q;
    wait_d  = (wait_q && !rd_resp_valid_i) || rd_fire;
    stale_d = stale_q && !rd_resp_valid_i;
    case (state_q)
      S_IDLE: begin
        if (conv_start_i) begin
          ifm_d   = conv_ifm_offset_i;
          ofm_d   = conv_ofm_offset_i;
          wt_d    = conv_wt_offset_i;
          dim_d   = conv_fm_dim_i[15:0];
          r_d     = '0;
          c_d     = '0;
          ky_d    = '0;
          kx_d    = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = (conv_fm_dim_i[15:0] == 16'd0) ? S_DONE : S_LOAD_WT;
        end
      end
      S_LOAD_WT: begin
        if (resp) begin
          k_d = last_tap ? '0 : k_q + KW'(1);
          if (last_tap) state_d = S_TAP;
        end
      end
      S_TAP: begin
        // Out-of-bounds taps retire in one cycle; in-bounds ones wait for their operand.
        if (!inb || resp) begin
          if (inb) acc_d = acc_q + rd_resp_data_i * w_q[k_q];
          if (last_tap) begin
            k_d     = '0;
            ky_d    = '0;
            kx_d    = '0;
            state_d = S_WRITE;
          end else begin
            k_d = k_q + KW'(1);
            if (kx_q == TW'(WT_DIM - 1)) begin
              kx_d = '0;
              ky_d = ky_q + TW'(1);
            end else begin
              kx_d = kx_q + TW'(1);
            end
          end
        end
      end
      S_WRITE: begin
        if (wr_req_ready_i) begin
          acc_d   = '0;
          state_d = S_TAP;
          if (c_q == dim_q - 16'd1) begin
            c_d = '0;
            if (r_q == dim_q - 16'd1) state_d = S_DONE;
            else r_d = r_q + 16'd1;
          end else begin
            c_d = c_q + 16'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (conv_rst_i) begin
      state_d = S_IDLE;
      wait_d  = 1'b0;
      stale_d = ((stale_q || wait_q) && !rd_resp_valid_i) || rd_fire;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ifm_q   <= '0;
      ofm_q   <= '0;
      wt_q    <= '0;
      dim_q   <= '0;
      r_q     <= '0;
      c_q     <= '0;
      ky_q    <= '0;
      kx_q    <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      wait_q  <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ifm_q   <= ifm_d;
      ofm_q   <= ofm_d;
      wt_q    <= wt_d;
      dim_q   <= dim_d;
      r_q     <= r_d;
      c_q     <= c_d;
      ky_q    <= ky_d;
      kx_q    <= kx_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      wait_q  <= wait_d;
      stale_q <= stale_d;
    end
  end

  for (genvar gi = 0; gi < NTAP; gi++) begin : g_wt
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) w_q[gi] <= '0;
      else if (w_we && (k_q == KW'(gi))) w_q[gi] <= rd_resp_data_i;
    end
  end

endmodule

// File: tb/tb_conv2d_engine.sv
// Scoreboard bench for conv2d_engine: memory responder, write monitor and a loop-based convolution model.
module tb_conv2d_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        conv_start_i, conv_rst_i;
  logic [31:0] conv_ifm_offset_i, conv_ofm_offset_i, conv_wt_offset_i, conv_fm_dim_i;
  logic        conv_idle_o, conv_done_o;
  logic        rd_req_valid_o, rd_req_ready_i;
  logic [31:0] rd_req_addr_o;
  logic        rd_resp_valid_i;
  logic [31:0] rd_resp_data_i;
  logic        wr_req_valid_o, wr_req_ready_i;
  logic [31:0] wr_req_addr_o, wr_req_data_o;

  always #5 clk = ~clk;

  conv2d_engine dut (
    .clk(clk), .rst(rst),
    .conv_start_i(conv_start_i), .conv_rst_i(conv_rst_i),
    .conv_ifm_offset_i(conv_ifm_offset_i), .conv_ofm_offset_i(conv_ofm_offset_i),
    .conv_wt_offset_i(conv_wt_offset_i), .conv_fm_dim_i(conv_fm_dim_i),
    .conv_idle_o(conv_idle_o), .conv_done_o(conv_done_o),
    .rd_req_valid_o(rd_req_valid_o), .rd_req_ready_i(rd_req_ready_i), .rd_req_addr_o(rd_req_addr_o),
    .rd_resp_valid_i(rd_resp_valid_i), .rd_resp_data_i(rd_resp_data_i),
    .wr_req_valid_o(wr_req_valid_o), .wr_req_ready_i(wr_req_ready_i),
    .wr_req_addr_o(wr_req_addr_o), .wr_req_data_o(wr_req_data_o)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  int          checks = 0, errors = 0;
  logic [31:0] mem [logic [31:0]];
  wr_t         exp_q [$];
  wr_t         mon_e;
  int          rd_count = 0, wr_count = 0, done_count = 0;
  bit          stall_en = 0;
  int          max_lat = 0, fix_lat = -1;
  bit          pend = 0;
  logic [31:0] pend_addr;
  int          cnt;
  bit          prev_rd_stall = 0, prev_wr_stall = 0;
  logic [31:0] prev_rd_addr, prev_wr_addr, prev_wr_data;
  int          ifm_v [64];
  int          wt_v [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Memory responder: decides ready at each falling edge and returns read data after a latency.
  initial begin
    rd_req_ready_i = 0; wr_req_ready_i = 0; rd_resp_valid_i = 0; rd_resp_data_i = 0;
    forever begin
      @(negedge clk);
      if (stall_en && prev_rd_stall) begin
        chk("rd_hold_valid", 32'(rd_req_valid_o), 32'd1);
        chk("rd_hold_addr", rd_req_addr_o, prev_rd_addr);
      end
      if (stall_en && prev_wr_stall) begin
        chk("wr_hold_addr", wr_req_addr_o, prev_wr_addr);
        chk("wr_hold_data", wr_req_data_o, prev_wr_data);
      end
      rd_resp_valid_i = 0;
      if (pend) begin
        if (cnt == 0) begin
          rd_resp_valid_i = 1;
          rd_resp_data_i  = mem_read(pend_addr);
          pend = 0;
        end else cnt--;
      end
      rd_req_ready_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_req_ready_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_req_valid_o && rd_req_ready_i) begin
        pend      = 1;
        pend_addr = rd_req_addr_o;
        cnt       = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, max_lat));
        rd_count++;
      end
      prev_rd_stall = rd_req_valid_o && !rd_req_ready_i;
      prev_rd_addr  = rd_req_addr_o;
      prev_wr_stall = wr_req_valid_o && !wr_req_ready_i;
      prev_wr_addr  = wr_req_addr_o;
      prev_wr_data  = wr_req_data_o;
    end
  end

  // Monitor: pops the scoreboard on every accepted write and counts done pulses.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (conv_done_o) done_count++;
      if (wr_req_valid_o && wr_req_ready_i) begin
        wr_count++;
        $display("wr addr=0x%08h data=0x%08h", wr_req_addr_o, wr_req_data_o);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write", wr_req_addr_o, wr_req_data_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", wr_req_addr_o, mon_e.addr);
          chk("wr_data", wr_req_data_o, mon_e.data);
        end
        mem[wr_req_addr_o] = wr_req_data_o;
      end
    end
  end

  task automatic pulse_start(input logic [31:0] ifm_b, ofm_b, wt_b, input int dim);
    @(negedge clk);
    conv_ifm_offset_i = ifm_b; conv_ofm_offset_i = ofm_b; conv_wt_offset_i = wt_b;
    conv_fm_dim_i = {16'($urandom), 16'(dim)};
    conv_start_i = 1;
    @(negedge clk);
    conv_start_i = 0;
    conv_ifm_offset_i = $urandom; conv_ofm_offset_i = $urandom; conv_wt_offset_i = $urandom;
    conv_fm_dim_i = $urandom;
  endtask

  task automatic run_conv(input string name, input logic [31:0] ifm_b, ofm_b, wt_b,
                          input int dim, input bit inject);
    int  acc, iy, ix, nreads, cyc, rd0, wr0, d0;
    wr_t e;
    for (int i = 0; i < dim * dim; i++) begin
      mem[ifm_b + 32'(4 * i)] = ifm_v[i];
      mem[ofm_b + 32'(4 * i)] = 32'hDEADBEEF;
    end
    for (int k = 0; k < 9; k++) mem[wt_b + 32'(4 * k)] = wt_v[k];
    nreads = (dim > 0) ? 9 : 0;
    for (int r = 0; r < dim; r++)
      for (int c = 0; c < dim; c++) begin
        acc = 0;
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++) begin
            iy = r + ky - 1;
            ix = c + kx - 1;
            if (iy >= 0 && iy < dim && ix >= 0 && ix < dim) begin
              acc += ifm_v[iy * dim + ix] * wt_v[ky * 3 + kx];
              nreads++;
            end
          end
`ifdef CONV_RELU_EN
        if (acc < 0) acc = 0;
`endif
        e.addr = ofm_b + 32'(4 * (r * dim + c));
        e.data = acc;
        exp_q.push_back(e);
      end
    rd0 = rd_count; wr0 = wr_count; d0 = done_count;
    pulse_start(ifm_b, ofm_b, wt_b, dim);
    #2;
    chk({name, "_busy"}, 32'(conv_idle_o), 32'd0);
    if (inject && dim > 0) begin
      cyc = 0;
      while (rd_count - rd0 < 10 && cyc < 2000) begin @(negedge clk); #2; cyc++; end
      conv_start_i = 1;
      @(negedge clk);
      conv_start_i = 0;
    end
    cyc = 0;
    while (done_count == d0 && cyc < 20000) begin @(negedge clk); #2; cyc++; end
    if (done_count == d0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done pulse, required one", name);
    end
    if (dim == 0) chk({name, "_latency_ok"}, 32'(cyc <= 3), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    chk({name, "_done_pulses"}, 32'(done_count - d0), 32'd1);
    chk({name, "_reads"}, 32'(rd_count - rd0), 32'(nreads));
    chk({name, "_writes"}, 32'(wr_count - wr0), 32'(dim * dim));
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_idle"}, 32'(conv_idle_o), 32'd1);
    exp_q.delete();
    $display("run %s dim=%0d reads=%0d writes=%0d", name, dim, rd_count - rd0, wr_count - wr0);
  endtask

  task automatic set_ones();
    for (int i = 0; i < 9; i++) begin ifm_v[i] = i + 1; wt_v[i] = 1; end
  endtask

  initial begin
    int rd0, wr0, d0, cyc, dim;
    rst = 0; conv_start_i = 0; conv_rst_i = 0;
    conv_ifm_offset_i = 0; conv_ofm_offset_i = 0; conv_wt_offset_i = 0; conv_fm_dim_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_idle", 32'(conv_idle_o), 32'd1);
    chk("rst_done", 32'(conv_done_o), 32'd0);
    chk("rst_rd_valid", 32'(rd_req_valid_o), 32'd0);
    chk("rst_wr_valid", 32'(wr_req_valid_o), 32'd0);
    chk("rst_wr_data", wr_req_data_o, 32'd0);
    rst = 1;
    @(negedge clk); #2;
    chk("post_rst_idle", 32'(conv_idle_o), 32'd1);

    run_conv("dim0", 32'h1000, 32'h8000, 32'h0100, 0, 0);

    set_ones();
    run_conv("ones", 32'h1000, 32'h8000, 32'h0100, 3, 0);
    chk("ones_out00", mem_read(32'h8000), 32'd12);
    chk("ones_out11", mem_read(32'h8010), 32'd45);
    chk("ones_out22", mem_read(32'h8020), 32'd28);

    for (int i = 0; i < 9; i++) wt_v[i] = (i == 4) ? 5 : 0;
    ifm_v[0] = 7;
    run_conv("center5", 32'h2000, 32'h9000, 32'h0200, 1, 0);
    chk("center5_out", mem_read(32'h9000), 32'd35);

    set_ones();
    stall_en = 1; max_lat = 5;
    run_conv("ones_stall", 32'h1000, 32'h8400, 32'h0100, 3, 0);
    chk("stall_out00", mem_read(32'h8400), 32'd12);
    chk("stall_out11", mem_read(32'h8410), 32'd45);
    chk("stall_out22", mem_read(32'h8420), 32'd28);

    // Abort with a tap read outstanding; its response lands two cycles after the abort.
    stall_en = 0; fix_lat = 2;
    rd0 = rd_count; wr0 = wr_count; d0 = done_count;
    pulse_start(32'h1000, 32'h8800, 32'h0100, 3);
    cyc = 0;
    do begin @(negedge clk); #2; cyc++; end while (rd_count - rd0 < 12 && cyc < 500);
    @(negedge clk); #2;
    conv_rst_i = 1;
    @(negedge clk);
    conv_rst_i = 0;
    #2;
    chk("abort_idle", 32'(conv_idle_o), 32'd1);
    chk("abort_rd_valid", 32'(rd_req_valid_o), 32'd0);
    chk("abort_wr_valid", 32'(wr_req_valid_o), 32'd0);
    rd0 = rd_count;
    repeat (15) @(negedge clk);
    #2;
    chk("abort_no_reads", 32'(rd_count - rd0), 32'd0);
    chk("abort_no_writes", 32'(wr_count - wr0), 32'd0);
    chk("abort_no_done", 32'(done_count - d0), 32'd0);
    fix_lat = -1;
    run_conv("after_abort", 32'h1000, 32'h8800, 32'h0100, 3, 0);
    chk("after_abort_out11", mem_read(32'h8810), 32'd45);

    for (int i = 0; i < 9; i++) wt_v[i] = (i == 4) ? -1 : 0;
    ifm_v[0] = 4;
    run_conv("neg_inject", 32'h3000, 32'hA000, 32'h0300, 1, 1);
`ifdef CONV_RELU_EN
    chk("neg_out", mem_read(32'hA000), 32'h0);
`else
    chk("neg_out", mem_read(32'hA000), 32'hFFFFFFFC);
`endif

    stall_en = 1;
    for (int t = 0; t < 6; t++) begin
      dim = int'($urandom_range(1, 5));
      for (int i = 0; i < dim * dim; i++)
        ifm_v[i] = (t % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
      for (int k = 0; k < 9; k++)
        wt_v[k] = (t % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 20)) - 10;
      run_conv($sformatf("rand%0d", t), 32'h4000 + 32'(t * 4), 32'hB000 + 32'(t * 256),
               32'h0400 + 32'(t * 64), dim, bit'(t % 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv2d_engine.md
Name: conv2d_engine

Overview:
Compute engine downstream of the convolution MMIO controller. Consumes start/soft-reset strobes and the four scalar configuration words, and returns idle/done status.
Performs a same-size, zero-padded 2D convolution of a square fm_dim x fm_dim feature map with a WT_DIM x WT_DIM kernel. All operands and results live in data memory, reached over a single-outstanding read port and a posted write port.

Parameters:
DWIDTH, 32, element/accumulator width (signed two's complement)
AWIDTH, 32, byte-address width
WT_DIM, 3, kernel side length (odd; pad = WT_DIM/2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
conv_start_i  in  1  start strobe, one cycle
conv_rst_i  in  1  synchronous soft abort strobe, one cycle
conv_ifm_offset_i  in  AWIDTH  input feature map base byte address
conv_ofm_offset_i  in  AWIDTH  output feature map base byte address
conv_wt_offset_i  in  AWIDTH  kernel base byte address
conv_fm_dim_i  in  32  feature map side; bits [15:0] used
conv_idle_o  out  1  high when in IDLE
conv_done_o  out  1  one-cycle completion pulse
rd_req_valid_o  out  1  read request valid
rd_req_ready_i  in  1  read request accepted
rd_req_addr_o  out  AWIDTH  read byte address
rd_resp_valid_i  in  1  read data valid
rd_resp_data_i  in  DWIDTH  read data
wr_req_valid_o  out  1  write request valid
wr_req_ready_i  in  1  write accepted
wr_req_addr_o  out  AWIDTH  write byte address
wr_req_data_o  out  DWIDTH  write data

Behaviour:
- Reset (rst low, async): state IDLE; conv_idle_o=1. All other outputs 0. Counters, accumulator and weight regs 0.
- Addressing: element (r,c) is at base + 4*(r*dim+c); weight k is at wt_offset + 4*k. All arithmetic is mod 2^AWIDTH.
- States:
  - IDLE: on conv_start_i, latch the four config inputs. If dim==0, go to DONE; otherwise go to LOAD_WT. Start strobes outside IDLE are ignored.
  - LOAD_WT: issue WT_DIM^2 reads in index order, one outstanding at a time. Each rd_resp_valid_i stores into weight reg k. Then go to TAP.
  - TAP: for output (r,c), walk taps ky,kx = 0..WT_DIM-1, row-major. Input coordinate is (r+ky-pad, c+kx-pad).
    - Out-of-bounds taps contribute 0, issue no read, and take 1 cycle.
    - In-bound taps issue a read; on response, acc += data*w[ky*WT_DIM+kx]. Product is truncated to DWIDTH; accumulation wraps mod 2^DWIDTH.
    - acc clears at the start of each pixel. After the last tap, go to WRITE.
  - WRITE: hold wr_req_valid_o with ofm address/acc until wr_req_ready_i. Then advance c, or r with c wrapping to 0. After (dim-1,dim-1), go to DONE; else go to TAP.
  - DONE: conv_done_o=1 for exactly one cycle; next state IDLE.
- Handshake: rd_req_valid_o stays high, with addr stable, until rd_req_ready_i. No new request is issued until its response returns. Response latency is unbounded.
- conv_rst_i, any state: next state IDLE and all valids drop next cycle. Any stale rd_resp_valid_i arriving in IDLE is discarded. No done pulse. Takes priority over a same-cycle conv_start_i.
- Config inputs are ignored outside the IDLE start cycle; mid-run changes have no effect.

Optional Feature:
CONV_RELU_EN:
- Defined: the write data is acc clamped to 0 when acc[DWIDTH-1]=1.
- Undefined: the raw wrapped acc is written.

Test Plan:
- dim=0, start -> done pulses 2 cycles after start; zero rd/wr requests; idle back to 1.
- dim=3, ifm=1..9 row-major, all weights 1, ready always 1, 1-cycle resp -> 58 reads (9 wt + 49 taps), 9 writes; out(0,0)=12, out(1,1)=45, out(2,2)=28; one done pulse.
- dim=1, weights {0,0,0,0,5,0,0,0,0}, ifm=7 -> single write of 35 to ofm_offset; exactly 10 reads.
- Same as the dim=3 case with rd_req_ready_i and wr_req_ready_i randomly low 50% and resp latency 0-5 cycles -> identical outputs; addr/data stable while valid and not ready.
- conv_rst_i mid-TAP with a read outstanding, response arriving 2 cycles later -> idle=1 next cycle, no further requests, no done; a fresh start then gives correct results.
- CONV_RELU_EN defined, dim=1, center weight -1, ifm=4 -> writes 0; undefined -> writes 0xFFFFFFFC. conv_start_i during TAP -> ignored.
